// File: rtl/hold_arb_pkg.sv
// Shared types and default widths for the holding-register arbiter.
package hold_arb_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_NUM_REQ   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search starting at ptr; one-hot grant plus encoded winner.
module rr_arbiter #(
  parameter int num_req   = 4,
  parameter int src_width = $clog2(num_req)
) (
  input  logic                 en,
  input  logic [num_req-1:0]   req,
  input  logic [src_width-1:0] ptr,
  output logic [num_req-1:0]   grant,
  output logic [src_width-1:0] win_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < num_req; i++) begin
      // Rotated index, wrapped without a modulo operator.
      idx = int'(ptr) + i;
      if (idx >= num_req) idx = idx - num_req;
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        win_idx      = src_width'(idx);
      end
    end
  end

endmodule

// File: rtl/hold_reg_arbiter.sv
// Round-robin writer arbitration for one shared holding register with valid/ready output.
// Optional same-cycle reload on consumption: HOLD_REG_ARBITER_BACK2BACK_EN.
module hold_reg_arbiter
  import hold_arb_pkg::*;
#(
  parameter int word_size = DEF_WORD_SIZE,
  parameter int num_req   = DEF_NUM_REQ,
  parameter int src_width = $clog2(num_req)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_req-1:0]           req,
  input  logic [num_req*word_size-1:0] req_data,
  output logic [num_req-1:0]           grant,
  output logic [word_size-1:0]         out_data,
  output logic [src_width-1:0]         out_src,
  output logic                         out_valid,
  input  logic                         out_ready
);

  state_t                state, state_nxt;
  logic [src_width-1:0]  ptr;
  logic [src_width-1:0]  win_idx;
  logic                  arb_en;
  logic                  load;

  rr_arbiter #(
    .num_req   (num_req),
    .src_width (src_width)
  ) u_rr (
    .en      (arb_en),
    .req     (req),
    .ptr     (ptr),
    .grant   (grant),
    .win_idx (win_idx)
  );

  assign load      = |grant;
  assign out_valid = (state == ST_FULL);

  always_comb begin
    arb_en    = 1'b0;
    state_nxt = state;
    unique case (state)
      ST_EMPTY: begin
        arb_en = !reset;
        if (load) state_nxt = ST_FULL;
      end
      ST_FULL: begin
`ifdef HOLD_REG_ARBITER_BACK2BACK_EN
        // Consumed word frees the register at this edge, so a new writer may load now.
        arb_en = !reset && out_ready;
`endif
        if (out_ready) state_nxt = load ? ST_FULL : ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_src  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        out_data <= req_data[int'(win_idx)*word_size +: word_size];
        out_src  <= win_idx;
        ptr      <= (win_idx == src_width'(num_req-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hold_reg_arbiter.sv
// Scoreboard bench for hold_reg_arbiter: directed scenarios then randomized requesters.
module tb_hold_reg_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = $clog2(N);
`ifdef HOLD_REG_ARBITER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct {
    logic [SW-1:0] src;
    logic [W-1:0]  data;
  } word_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready;

  hold_reg_arbiter #(.word_size(W), .num_req(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_fail = 0;
  word_t        exp_q[$];
  logic [W-1:0] dat [N];
  int           m_ptr;
  bit           m_full;
  int           last_w;
  logic [N-1:0] last_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference winner: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One cycle: drive, check grant against the model, advance the model, clock.
  task automatic step(input logic [N-1:0] r, input logic rdy);
    int           w;
    logic [N-1:0] eg;
    word_t        e;
    req       = r;
    out_ready = rdy;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = dat[i];
    #1;
    eg = '0;
    w  = -1;
    if (!m_full || (B2B && rdy)) w = pick(r, m_ptr);
    if (w >= 0) eg[w] = 1'b1;
    chk("grant", 64'(grant), 64'(eg));
    last_w = w;
    last_g = grant;
    if (w >= 0) begin
      e.src  = SW'(w);
      e.data = dat[w];
      exp_q.push_back(e);
      m_ptr  = (w + 1) % N;
      m_full = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_full));
  endtask

  task automatic do_reset(input int n, input logic [N-1:0] r);
    reset     = 1'b1;
    req       = r;
    out_ready = 1'b0;
    #1;
    chk("reset_grant", 64'(grant), 64'(0));
    repeat (n) @(posedge clk);
    #1;
    chk("reset_grant_hold", 64'(grant), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_data", 64'(out_data), 64'(0));
    chk("reset_src", 64'(out_src), 64'(0));
    exp_q.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    reset  = 1'b0;
  endtask

  // Monitor: whenever a word is presented it must be the oldest outstanding write.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(out_valid), 64'(0));
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q[0].data));
        chk("out_src", 64'(out_src), 64'(exp_q[0].src));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int           ng;
    int           order [5];
    logic [N-1:0] pend;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    out_ready = 1'b0;
    m_full   = 1'b0;
    m_ptr    = 0;
    for (int i = 0; i < N; i++) dat[i] = 32'h1000_0000 + W'(i);

    do_reset(2, 4'b1111);

    // Single requester, then stall with other requests pending.
    dat[2] = 32'hDEADBEEF;
    step(4'b0100, 1'b0);
    chk("single_grant", 64'(last_g), 64'(4'b0100));
    chk("single_data", 64'(out_data), 64'(32'hDEADBEEF));
    chk("single_src", 64'(out_src), 64'(2));
    for (int c = 0; c < 5; c++) begin
      step(4'b0011, 1'b0);
      chk("stall_grant", 64'(last_g), 64'(0));
    end
    chk("stall_data", 64'(out_data), 64'(32'hDEADBEEF));
    step(4'b0000, 1'b1);

    // Fairness from a fresh pointer with everyone requesting.
    do_reset(1, 4'b0000);
    ng = 0;
    for (int c = 0; c < 12 && ng < 5; c++) begin
      step(4'b1111, 1'b1);
      if (last_w >= 0) begin
        order[ng] = last_w;
        ng++;
      end
    end
    chk("rr_count", 64'(ng), 64'(5));
    chk("rr_0", 64'(order[0]), 64'(0));
    chk("rr_1", 64'(order[1]), 64'(1));
    chk("rr_2", 64'(order[2]), 64'(2));
    chk("rr_3", 64'(order[3]), 64'(3));
    chk("rr_4", 64'(order[4]), 64'(0));
    step(4'b0000, 1'b1);

    // Consumption with a requester waiting.
    do_reset(1, 4'b0000);
    dat[0] = 32'hA5A5_0000;
    dat[3] = 32'h3333_3333;
    step(4'b0001, 1'b0);
    step(4'b1000, 1'b1);
    chk("b2b_first", 64'(last_g), B2B ? 64'(4'b1000) : 64'(0));
    step(4'b1000, 1'b1);
    chk("b2b_second", 64'(last_g), 64'(4'b1000));
    step(4'b0000, 1'b1);

    // Reset while full discards the word and the pointer.
    do_reset(1, 4'b0000);
    dat[1] = 32'h12345678;
    step(4'b0010, 1'b0);
    chk("mid_data", 64'(out_data), 64'(32'h12345678));
    do_reset(1, 4'b0000);
    step(4'b1010, 1'b0);
    chk("post_reset_grant", 64'(last_g), 64'(4'b0010));
    step(4'b0000, 1'b1);

    // Randomized requesters honoring the hold-until-granted contract, with retractions.
    pend = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          dat[i]  = $urandom;
        end else if (pend[i] && ($urandom % 20 == 0)) begin
          pend[i] = 1'b0;
        end
      end
      step(pend, ($urandom % 4) != 0);
      if (last_w >= 0) pend[last_w] = 1'b0;
    end

    repeat (3) step(4'b0000, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hold_reg_arbiter.md
# hold_reg_arbiter

Round-robin arbiter that shares a single `word_size`-bit holding register between `num_req` requesters and presents its content to one downstream consumer with a valid/ready handshake. Sits between several producer stages and a shared operand/result holding register in the CPU datapath. It sequences register writes so that exactly one producer loads the register at a time and no held word is overwritten before the consumer takes it.

## Interface
Parameters:
- `word_size`, 32: data width in bits.
- `num_req`, 4: number of requesters; must be at least 2.
- `src_width`, `$clog2(num_req)`: width of the source ID.

Ports:
- `clk`  input  1  clock. All state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  `num_req`  per-requester write request. Bit i belongs to requester i.
- `req_data`  input  `num_req*word_size`  packed data. Requester i drives bits `[i*word_size +: word_size]`.
- `grant`  output  `num_req`  one-hot write grant (combinational). Contains at most one set bit.
- `out_data`  output  `word_size`  held word.
- `out_src`  output  `src_width`  index of the requester that wrote `out_data`.
- `out_valid`  output  1  the register holds an unconsumed word.
- `out_ready`  input  1  the consumer accepts `out_data` in this cycle.

## Operation
- Two-state FSM:
  - **EMPTY**: `out_valid` = 0.
  - **FULL**: `out_valid` = 1.
- **EMPTY, with any `req` set:**
  - The round-robin winner gets `grant` in the same cycle.
  - The winner's data and index are loaded at the next edge.
  - The FSM moves to FULL.
- **EMPTY, with `req` = 0:** remain in EMPTY. `grant` = 0.
- **FULL, with `out_ready` = 0:** hold `out_data` and `out_src`. `grant` = 0. All requests stall.
- **FULL, with `out_ready` = 1:** the word is consumed at this edge.
  - Next state is EMPTY, except in the back-to-back case described under Configuration.
- **Round-robin policy:**
  - A priority pointer `ptr` gives the highest-priority index.
  - The search starts at `ptr` and wraps modulo `num_req`.
  - When a grant occurs, `ptr` becomes the winner index + 1, wrapping from `num_req-1` to 0.
  - `ptr` does not change when there is no grant.
- **Requester contract:** hold `req` and `req_data` stable until `grant[i]` is seen. `req` is treated as dropped at the edge where `grant[i]` = 1.
- **Retracted requests:** a request dropped before it is granted is simply not considered. No error is raised.
- **Reset:** reset mid-operation discards the held word immediately. No pending grant completes.

## Timing
- Reset values:
  - `out_data` = 0, `out_src` = 0, `out_valid` = 0.
  - `ptr` = 0, FSM = EMPTY.
  - `grant` = 0 while `reset` is high.
- `grant` is a Mealy output and depends on `req`, `ptr`, FSM state, and `out_ready` (back-to-back case only).
- Write latency: a grant in cycle N gives `out_valid` = 1 and the new data in cycle N+1.
- Handshake: a transfer happens in a cycle where `out_valid` && `out_ready`. `out_data` must not change while `out_valid` = 1 && `out_ready` = 0.
- `out_ready` has no effect while in EMPTY.
- Throughput without back-to-back: one word every 2 cycles at most. This comes from a bubble cycle in EMPTY after each consumption.

## Configuration
- Macro: `HOLD_REG_ARBITER_BACK2BACK_EN`.
- **Defined:** in FULL with `out_ready` = 1 and any `req` set, the arbiter grants in the same cycle.
  - The register reloads at the same edge where the old word is consumed.
  - The FSM stays in FULL, so sustained throughput is 1 word per cycle.
- **Undefined:** `grant` is only ever asserted in EMPTY. Every consumption costs one EMPTY cycle.

## Structure
- **Shared package `hold_arb_pkg`:**
  - FSM state typedef: `ST_EMPTY`, `ST_FULL`.
  - Default width constants.
- **Sub-module `rr_arbiter`:**
  - Combinational priority search from `ptr` over `req`, gated by an enable.
  - Produces a one-hot `grant` and an encoded winner index.
  - The `ptr` register stays in the top level.
- **Top level** holds the FSM, data/source registers, and data mux.

## Test plan
- Reset check: apply reset for 2 cycles with `req` = 4'b1111.
  - Required response: `grant` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0.
- Single requester: `req` = 4'b0100, data2 = 32'hDEADBEEF in EMPTY.
  - Required response: `grant` = 4'b0100 in the same cycle.
  - Next cycle: `out_valid` = 1, `out_data` = 32'hDEADBEEF, `out_src` = 2.
- Round-robin fairness: `req` = 4'b1111 held, `out_ready` = 1.
  - Required response: grant order is 0, 1, 2, 3, 0.
  - `out_src` follows the same order.
- Stall: FULL with `out_ready` = 0 for 5 cycles while `req` = 4'b0011.
  - Required response: `grant` = 0 throughout; `out_data` and `out_src` unchanged.
- Back-to-back case: FULL, `out_ready` = 1, `req` = 4'b1000.
  - Macro defined: `grant` = 4'b1000 this cycle; `out_valid` stays 1 with the new data next cycle.
  - Macro undefined: `grant` = 0; next cycle `out_valid` = 0 with `grant` = 4'b1000.
- Reset mid-operation: assert reset while FULL holding 32'h12345678.
  - Required response: next cycle `out_valid` = 0, `out_data` = 0, `ptr` = 0.
  - First grant after reset goes to the lowest requester index that is requesting.
